// File: rtl/seq_detector_param_pkg.sv
// Shared defaults, the match-mode type and the length-legality rule for the serial
// pattern detector and its helpers.
package seq_detector_param_pkg;

  localparam int unsigned DEF_MAX_LEN   = 4;
  localparam logic [3:0]  DEF_PATTERN_P = 4'b1011;
  localparam int unsigned DEF_LEN_P     = 4;
  localparam bit          DEF_OVERLAP_P = 1'b1;
  localparam int unsigned DEF_CNT_W     = 8;

  typedef enum logic {
    MODE_DISJOINT = 1'b0,
    MODE_OVERLAP  = 1'b1
  } match_mode_e;

  function automatic bit len_is_legal(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: pulses y_out one cycle after the
// accepted bit that completes the pattern, and counts matches.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_P),
  parameter int                 DEF_LEN     = DEF_LEN_P,
  parameter bit                 DEF_OVERLAP = DEF_OVERLAP_P,
  parameter int                 CNT_W       = DEF_CNT_W,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  input  logic               x_input,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y_out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [MAX_LEN:0] MASK_ONE = (MAX_LEN + 1)'(1);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  match_mode_e        mode_q, mode_d;
  logic               y_q, y_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN:0]   mask_wide;
  logic [MAX_LEN-1:0] mask;
  logic               cnt_inc;
  logic               cnt_clr;

  // One extra bit so that len == MAX_LEN still yields an all-ones mask.
  assign mask_wide = (MASK_ONE << len_q) - MASK_ONE;
  assign mask      = mask_wide[MAX_LEN-1:0];

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    len_d      = len_q;
    mode_d     = mode_q;
    err_d      = err_q;
    y_d        = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    hist_shift = hist_q << 1;
    hist_shift[0] = x_input;

    if (cfg_load) begin
      if (len_is_legal(32'(cfg_len), MAX_LEN)) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        mode_d  = match_mode_e'(cfg_overlap);
        hist_d  = '0;
        fill_d  = '0;
        cnt_clr = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (x_valid) begin
      hist_d = hist_shift;
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_ONE;
      if ((fill_d >= len_q) && ((hist_shift & mask) == (pat_q & mask))) begin
        y_d     = 1'b1;
        cnt_inc = 1'b1;
        // Disjoint mode: forget every bit of this match so none is reused.
        if (mode_q == MODE_DISJOINT) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      mode_q <= match_mode_e'(DEF_OVERLAP);
      y_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      y_q    <= y_d;
      err_q  <= err_d;
    end
  end

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .q   (match_cnt)
  );

  assign y_out   = y_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (default, 2-bit counter, MAX_LEN=1)
// share one stimulus stream and are checked every cycle against a bit-list model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x_valid = 1'b0;
  logic       x_input = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;

  logic       y0, y1, y2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;
  logic       err0, err1, err2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param u0 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_input(x_input),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .y_out(y0), .match_cnt(cnt0), .cfg_err(err0)
  );

  seq_detector_param #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_input(x_input),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .y_out(y1), .match_cnt(cnt1), .cfg_err(err1)
  );

  seq_detector_param #(.MAX_LEN(1), .DEF_PATTERN(1'b1), .DEF_LEN(1)) u2 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_input(x_input),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern[0]), .cfg_len(cfg_len[0]),
    .cfg_overlap(cfg_overlap), .y_out(y2), .match_cnt(cnt2), .cfg_err(err2)
  );

  // Model: per instance, the list of accepted bits since the last clear
  // (m_last[i][0] is the newest) plus how many of them are usable.
  int m_maxl[3]   = '{4, 4, 1};
  int m_cntmax[3] = '{255, 3, 255};
  int m_pat[3];
  int m_len[3];
  int m_ovl[3];
  int m_nbits[3];
  int m_cnt[3];
  int m_err[3];
  int m_y[3];
  bit m_last[3][16];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pat[i]   = (i == 2) ? 1 : 11;
      m_len[i]   = (i == 2) ? 1 : 4;
      m_ovl[i]   = 1;
      m_nbits[i] = 0;
      m_cnt[i]   = 0;
      m_err[i]   = 0;
      m_y[i]     = 0;
      for (int k = 0; k < 16; k++) m_last[i][k] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int  len_in, pat_in;
    bit  hit;
    for (int i = 0; i < 3; i++) begin
      len_in = (i == 2) ? int'(cfg_len[0]) : int'(cfg_len);
      pat_in = (i == 2) ? int'(cfg_pattern[0]) : int'(cfg_pattern);
      m_y[i] = 0;
      if (cfg_load) begin
        if (len_in >= 1 && len_in <= m_maxl[i]) begin
          m_pat[i]   = pat_in;
          m_len[i]   = len_in;
          m_ovl[i]   = int'(cfg_overlap);
          m_nbits[i] = 0;
          m_cnt[i]   = 0;
          m_err[i]   = 0;
        end else begin
          m_err[i] = 1;
        end
      end else if (x_valid) begin
        for (int k = 15; k > 0; k--) m_last[i][k] = m_last[i][k-1];
        m_last[i][0] = x_input;
        m_nbits[i]++;
        hit = (m_nbits[i] >= m_len[i]);
        for (int k = 0; k < m_len[i]; k++)
          if (m_last[i][k] != ((m_pat[i] >> k) & 1)) hit = 1'b0;
        if (hit) begin
          m_y[i]   = 1;
          m_cnt[i] = (m_cnt[i] < m_cntmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
          if (m_ovl[i] == 0) m_nbits[i] = 0;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: every DUT output against the model, each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("y0", int'(y0), m_y[0]);     chk("cnt0", int'(cnt0), m_cnt[0]); chk("err0", int'(err0), m_err[0]);
      chk("y1", int'(y1), m_y[1]);     chk("cnt1", int'(cnt1), m_cnt[1]); chk("err1", int'(err1), m_err[1]);
      chk("y2", int'(y2), m_y[2]);     chk("cnt2", int'(cnt2), m_cnt[2]); chk("err2", int'(err2), m_err[2]);
    end
  end

  // Driver tasks: called at a falling edge, return at a falling edge.
  task automatic feed(input int n, input logic [31:0] bits, input logic [31:0] vld,
                      output logic [31:0] hits);
    hits = '0;
    for (int k = 0; k < n; k++) begin
      x_valid = vld[n-1-k];
      x_input = bits[n-1-k];
      @(posedge clk);
      @(negedge clk);
      hits[k+1] = y0;
    end
    x_valid = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] pat, input logic [2:0] len, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  logic [31:0] hits;
  logic [31:0] mixed;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_y", int'(y0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_err", int'(err0), 0);
    #1 rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Default 1011 overlapping: hits after bits 6, 9, 13.
    feed(15, 32'b101011011101110, 32'hFFFF_FFFF, hits);
    chk("t1_hits", int'(hits), 32'h2240);
    chk("t1_cnt", int'(cnt0), 3);

    // Same stream, non-overlapping: hits after bits 6 and 13.
    cfg(4'b1011, 3'd4, 1'b0);
    feed(15, 32'b101011011101110, 32'hFFFF_FFFF, hits);
    chk("t2_hits", int'(hits), 32'h2040);
    chk("t2_cnt", int'(cnt0), 2);

    // 111 length 3 overlapping on six ones.
    cfg(4'b0111, 3'd3, 1'b1);
    feed(6, 32'b111111, 32'hFFFF_FFFF, hits);
    chk("t3_hits", int'(hits), 32'h78);
    chk("t3_cnt", int'(cnt0), 4);

    // Gaps in x_valid are ignored.
    cfg(4'b1011, 3'd4, 1'b1);
    mixed = {26'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 2'b11};
    feed(6, mixed, 32'b101011, hits);
    chk("t4_hits", int'(hits), 32'h40);
    chk("t4_cnt", int'(cnt0), 1);

    // Asynchronous reset mid-stream loses the partial match.
    feed(3, 32'b101, 32'hFFFF_FFFF, hits);
    chk("t5_precnt", int'(cnt0), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_y", int'(y0), 0);
    chk("t5_async_cnt", int'(cnt0), 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    feed(1, 32'b1, 32'hFFFF_FFFF, hits);
    chk("t5_hits", int'(hits), 0);

    // Illegal lengths set the sticky error; a legal load clears it.
    cfg(4'b0000, 3'd0, 1'b1);
    chk("t6_err_len0", int'(err0), 1);
    cfg(4'b1111, 3'd5, 1'b0);
    chk("t6_err_len5", int'(err0), 1);
    cfg(4'b1011, 3'd4, 1'b1);
    chk("t6_err_clr", int'(err0), 0);
    feed(20, 32'hBBBBB, 32'hFFFF_FFFF, hits);
    chk("t6_hits", int'(hits), 32'h111110);
    chk("t6_cnt8", int'(cnt0), 5);
    chk("t6_cnt2_sat", int'(cnt1), 3);

    // Randomized traffic with occasional reconfiguration and resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cfg(4'($urandom_range(0, 15)), 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end else if (r < 4) begin
        x_valid = 1'($urandom_range(0, 1));
        x_input = 1'($urandom_range(0, 1));
        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
      end else begin
        x_valid = ($urandom_range(0, 3) != 0);
        x_input = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
      end
    end
    x_valid = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
